// File: rtl/bin2bcd_pkg.sv
// Shared types and defaults for the sequential binary-to-BCD converter.
// Contents:
//   BIN_W_DEF / DIGITS_DEF : default input width and number of output digits
//   b2b_state_t            : converter FSM state (IDLE, SHIFT)
//   bcd_digit_t            : one packed BCD digit
package bin2bcd_pkg;

  localparam int BIN_W_DEF  = 13;
  localparam int DIGITS_DEF = 4;

  typedef enum logic {IDLE, SHIFT} b2b_state_t;

  typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between the rounding stage, the converter and the
// display stage.
// Signals:
//   start  : request a conversion (only looked at while the converter is idle)
//   bin    : unsigned binary value, captured on the accepting edge
//   busy   : conversion in progress
//   done   : one-cycle pulse, bcd has just been updated
//   bcd    : packed BCD result, digit 0 in bits [3:0], held between conversions
//   blank  : leading-zero flags per digit (only with BIN2BCD_BLANK_EN)
// Handshake: start is a request, not a valid/ready pair. The converter takes
// it on a rising edge only while busy is low; start seen while busy is
// dropped, nothing is queued. Each accepted request yields exactly one done
// pulse, and bcd changes only in that cycle.
// Modports: master = requester/consumer, slave = converter.
interface bin2bcd_seq_if #(
  parameter int BIN_W  = 13,
  parameter int DIGITS = 4
);
  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0]     blank;

  modport master (output start, bin, input busy, done, bcd, blank);
  modport slave  (input start, bin, output busy, done, bcd, blank);
`else
  modport master (output start, bin, input busy, done, bcd);
  modport slave  (input start, bin, output busy, done, bcd);
`endif
endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or
// more, so that the following left shift carries correctly into the next
// digit. Inputs stay within 0..9 during a conversion, so the result never
// exceeds 12 and fits in the nibble.
// Ports:
//   d : digit before correction
//   q : digit after correction
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  bcd_digit_t d,
  output bcd_digit_t q
);

  assign q = (d >= 4'd5) ? bcd_digit_t'(d + 4'd3) : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per clock.
// A request accepted at edge k produces its result on edge k+BIN_W; done is
// high in the cycle after that edge and bcd holds until the next completion.
// Optional: define BIN2BCD_BLANK_EN to add the blank output (leading-zero
// flags, registered with bcd).
// Ports:
//   clk       : clock, rising edge
//   reset     : asynchronous, active-high; aborts any conversion
//   bus       : bin2bcd_seq_if slave (start, bin, busy, done, bcd[, blank])
//   state_dbg : current FSM state, for observation only
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = BIN_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic          clk,
  input  logic          reset,
  bin2bcd_seq_if.slave  bus,
  output b2b_state_t    state_dbg
);

  localparam int CNT_W  = $clog2(BIN_W + 1);
  localparam int WORK_W = 4 * DIGITS;

  // The largest input must be representable in DIGITS decimal digits.
  if ((2.0 ** BIN_W) > (10.0 ** DIGITS)) begin : g_width_check
    $error("bin2bcd_seq: DIGITS too small for BIN_W");
  end

  b2b_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   src_q, src_d;
  logic [WORK_W-1:0]  work_q, work_d;
  logic [WORK_W-1:0]  bcd_q, bcd_d;
  logic               done_q, done_d;
  logic [WORK_W-1:0]  adj;

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (work_q[4*i +: 4]),
      .q (adj[4*i +: 4])
    );
  end

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0]  blank_q, blank_d;
  logic [DIGITS-1:0]  blank_next;
  logic               hi_zero;

  // Walk from the top digit down; a digit is blank while it and every digit
  // above it are zero. The units digit is always shown.
  always_comb begin
    blank_next = '0;
    hi_zero    = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      hi_zero       = hi_zero & (work_d[4*i +: 4] == 4'd0);
      blank_next[i] = hi_zero;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    work_d  = work_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
`ifdef BIN2BCD_BLANK_EN
    blank_d = blank_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          src_d   = bus.bin;
          work_d  = '0;
          cnt_d   = CNT_W'(BIN_W);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Correct first, then shift {work, src} left; src MSB enters work.
        work_d = {adj[WORK_W-2:0], src_q[BIN_W-1]};
        src_d  = src_q << 1;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = work_d;
          done_d  = 1'b1;
          state_d = IDLE;
`ifdef BIN2BCD_BLANK_EN
          blank_d = blank_next;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      src_q   <= '0;
      work_q  <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
`ifdef BIN2BCD_BLANK_EN
      blank_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      work_q  <= work_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
`ifdef BIN2BCD_BLANK_EN
      blank_q <= blank_d;
`endif
    end
  end

  assign bus.busy  = (state_q == SHIFT);
  assign bus.done  = done_q;
  assign bus.bcd   = bcd_q;
`ifdef BIN2BCD_BLANK_EN
  assign bus.blank = blank_q;
`endif
  assign state_dbg = state_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: reset state, several conversions with
// hand-computed results, ignored start while busy, reset abort, and
// back-to-back conversions with start held high.
module tb_bin2bcd_seq;
  import bin2bcd_pkg::*;

  localparam int BIN_W  = 13;
  localparam int DIGITS = 4;

  logic       clk;
  logic       reset;
  b2b_state_t state_dbg;
  int         n_cmp;
  int         n_err;
  int         done_cnt;

  bin2bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial done_cnt = 0;
  always @(negedge clk) if (bus.done) done_cnt = done_cnt + 1;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

`ifdef BIN2BCD_BLANK_EN
  function automatic logic [DIGITS-1:0] blank_of(input logic [4*DIGITS-1:0] b);
    logic z;
    blank_of = '0;
    z = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      z = z & (b[4*i +: 4] == 4'd0);
      blank_of[i] = z;
    end
  endfunction
`endif

  // ---------------- driver tasks ----------------
  // Waits (bounded) for done; lat = clocks from the accepting edge, -1 on timeout.
  task automatic wait_done(output int lat, output int nb);
    lat = -1;
    nb  = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = c - 1;
        break;
      end
      if (bus.busy) nb++;
    end
  endtask

  task automatic convert(input logic [BIN_W-1:0] b, input logic [15:0] exp);
    int lat, nb;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.bin   = b;
    @(posedge clk); #1;          // accepting edge just passed
    bus.start = 1'b0;
    bus.bin   = 13'($urandom_range(0, 8191));
    wait_done(lat, nb);
    check("latency", lat, 13);
    check("busy_cycles", nb, 13);
    check("bcd", {16'h0, bus.bcd}, {16'h0, exp});
    check("busy_in_done", {31'h0, bus.busy}, 0);
`ifdef BIN2BCD_BLANK_EN
    check("blank", {28'h0, bus.blank}, {28'h0, blank_of(exp)});
`endif
    @(negedge clk);
    check("done_pulse", {31'h0, bus.done}, 0);
    check("bcd_hold", {16'h0, bus.bcd}, {16'h0, exp});
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] held_exp [3];
  int lat, nb, d0;

  initial begin
    n_cmp = 0;
    n_err = 0;
    held_exp[0] = 16'h0100;
    held_exp[1] = 16'h0101;
    held_exp[2] = 16'h0102;
    bus.start = 1'b0;
    bus.bin   = '0;
    reset     = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'h0, bus.busy}, 0);
    check("rst_done", {31'h0, bus.done}, 0);
    check("rst_bcd", {16'h0, bus.bcd}, 0);
    check("rst_state", {31'h0, state_dbg}, {31'h0, IDLE});
`ifdef BIN2BCD_BLANK_EN
    check("rst_blank", {28'h0, bus.blank}, 0);
`endif

    convert(13'd0,    16'h0000);
    convert(13'd8191, 16'h8191);
    convert(13'd4999, 16'h4999);
    convert(13'd5,    16'h0005);
    convert(13'd10,   16'h0010);
    convert(13'd42,   16'h0042);

    // start pulsed again while busy must be ignored
    d0 = done_cnt;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.bin   = 13'd1234;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.bin   = 13'd0;
    repeat (5) @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 13'd999;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (30) @(negedge clk);
    check("ignore_done_count", done_cnt - d0, 1);
    check("ignore_bcd", {16'h0, bus.bcd}, 32'h1234);
    check("ignore_busy", {31'h0, bus.busy}, 0);

    // reset in the middle of a conversion aborts it
    d0 = done_cnt;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.bin   = 13'd5678;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", {31'h0, bus.busy}, 0);
    check("abort_done", {31'h0, bus.done}, 0);
    check("abort_bcd", {16'h0, bus.bcd}, 0);
    check("abort_state", {31'h0, state_dbg}, {31'h0, IDLE});
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_idle", {31'h0, bus.busy}, 0);
    convert(13'd42, 16'h0042);

    // start held high: back-to-back conversions every BIN_W+1 clocks
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.bin   = 13'd100;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;          // accepting edge
      bus.bin = 13'(101 + i);
      wait_done(lat, nb);
      check("held_latency", lat, 13);
      check("held_busy", nb, 13);
      check("held_bcd", {16'h0, bus.bcd}, {16'h0, held_exp[i]});
      if (i == 2) bus.start = 1'b0;
    end
    @(negedge clk);
    check("held_stop", {31'h0, bus.busy}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
